// File: rtl/alarm_ctrl_pkg.sv
// Shared definitions for the intrusion alarm controller: state codes and
// counter sizing helper, also used by the sensor-decode top and the bench.
package alarm_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_e;

  // Countdown width covering the longest phase; never narrower than one bit.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (m < 2) return 1;
    else return $clog2(m);
  endfunction

endpackage

// File: rtl/alarm_ctrl_sync2.sv
// Two-flop synchronizer with async active-low reset, reusable for panel inputs.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm sequencer: arm -> exit delay -> armed -> entry delay -> siren, with
// disarm overriding everything. Outputs are registered decodes of the state.
module alarm_ctrl
  import alarm_ctrl_pkg::*;
#(
  parameter int EXIT_CYC  = 16,
  parameter int ENTRY_CYC = 8,
  parameter int ALARM_CYC = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         arm,
  input  logic         disarm,
  input  logic         trig,
  output logic         siren,
  output logic         armed,
  output logic         pending,
  output logic [2:0]   state
);

  localparam int CNT_W = cnt_width(EXIT_CYC, ENTRY_CYC, ALARM_CYC);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] EXIT_LD   = CNT_W'(EXIT_CYC - 1);
  localparam logic [CNT_W-1:0] ENTRY_LD  = CNT_W'(ENTRY_CYC - 1);
  localparam logic [CNT_W-1:0] ALARM_LD  = CNT_W'(ALARM_CYC - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             siren_q, armed_q, pending_q;
  logic             trig_s;

  sync2 u_trig_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (trig),
    .q     (trig_s)
  );

  // Next-state and countdown; disarm outranks arm, expiry and trigger.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (disarm && (state_q != S_DISARMED)) begin
      state_d = S_DISARMED;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        S_DISARMED: begin
          if (arm && !disarm) begin
            state_d = S_EXIT;
            cnt_d   = EXIT_LD;
          end else begin
            state_d = S_DISARMED;
          end
        end
        S_EXIT: begin
          if (cnt_q == CNT_ZERO) state_d = S_ARMED;
          else                   cnt_d   = cnt_q - CNT_ONE;
        end
        S_ARMED: begin
          if (trig_s) begin
            state_d = S_ENTRY;
            cnt_d   = ENTRY_LD;
          end else begin
            state_d = S_ARMED;
          end
        end
        S_ENTRY: begin
          if (cnt_q == CNT_ZERO) begin
            state_d = S_ALARM;
            cnt_d   = ALARM_LD;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        S_ALARM: begin
          if (cnt_q == CNT_ZERO) state_d = S_ARMED;
          else                   cnt_d   = cnt_q - CNT_ONE;
        end
        default: begin
          state_d = S_DISARMED;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // State, counter and output decode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_DISARMED;
      cnt_q     <= CNT_ZERO;
      siren_q   <= 1'b0;
      armed_q   <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      siren_q   <= (state_d == S_ALARM);
      armed_q   <= (state_d == S_EXIT) || (state_d == S_ARMED) ||
                   (state_d == S_ENTRY) || (state_d == S_ALARM);
      pending_q <= (state_d == S_EXIT) || (state_d == S_ENTRY);
    end
  end

  assign siren   = siren_q;
  assign armed   = armed_q;
  assign pending = pending_q;
  assign state   = state_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Directed table-driven bench for alarm_ctrl with EXIT=4, ENTRY=3, ALARM=5.
module tb_alarm_ctrl;

  localparam logic [2:0] DIS = 3'd0;
  localparam logic [2:0] EXT = 3'd1;
  localparam logic [2:0] ARM = 3'd2;
  localparam logic [2:0] ENT = 3'd3;
  localparam logic [2:0] ALM = 3'd4;

  typedef struct packed {
    logic       arm;
    logic       dis;
    logic       trig;
    logic [2:0] st;
    logic       sir;
    logic       armd;
    logic       pend;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       arm, disarm, trig;
  logic       siren, armed, pending;
  logic [2:0] state;

  int n_cmp;
  int n_bad;
  logic siren_seen;
  vec_t vecs[$];

  alarm_ctrl #(.EXIT_CYC(4), .ENTRY_CYC(3), .ALARM_CYC(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .arm     (arm),
    .disarm  (disarm),
    .trig    (trig),
    .siren   (siren),
    .armed   (armed),
    .pending (pending),
    .state   (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic a, input logic d, input logic t,
                              input logic [2:0] s);
    vec_t v;
    v.arm  = a;
    v.dis  = d;
    v.trig = t;
    v.st   = s;
    v.sir  = (s == ALM);
    v.armd = (s != DIS);
    v.pend = (s == EXT) || (s == ENT);
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] s);
    logic [5:0] got, exp;
    got = {state, siren, armed, pending};
    exp = {s, (s == ALM), (s != DIS), ((s == EXT) || (s == ENT))};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d siren=%b armed=%b pending=%b, want st=%0d siren=%b armed=%b pending=%b",
               name, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic step(input logic a, input logic d, input logic t);
    @(negedge clk);
    arm = a; disarm = d; trig = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; siren_seen = 1'b0;
    arm = 1'b0; disarm = 1'b0; trig = 1'b1;
    rst_n = 1'b0;
    #1;
    check("reset", DIS);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b1, DIS));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, EXT));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, EXT));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, ARM));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, ARM));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, ARM));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, ENT));
    for (int i = 0; i < 2; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, ENT));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(1'b0, 1'b0, 1'b0, ALM));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, ARM));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, ARM));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, DIS));
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, EXT));
    vecs.push_back(mk(1'b0, 1'b0, 1'b1, EXT));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, EXT));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, EXT));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, ARM));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, ARM));
    vecs.push_back(mk(1'b0, 1'b1, 1'b0, DIS));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, DIS));
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, DIS));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].arm, vecs[i].dis, vecs[i].trig);
      check($sformatf("vec%0d", i), vecs[i].st);
    end

    // Disarm while ENTRY has one count left: siren must never rise.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("pre_entry_armed", ARM);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("entry_cnt2", ENT);
    step(1'b0, 1'b0, 1'b1);
    check("entry_cnt1", ENT);
    step(1'b0, 1'b1, 1'b1);
    check("entry_disarm", DIS);
    if (siren) siren_seen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (siren) siren_seen = 1'b1;
    end
    n_cmp++;
    if (siren_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL siren_after_disarm: got siren_seen=%b, want 0", siren_seen);
    end

    // Trigger held through ALARM end: one ARMED cycle, then ENTRY again.
    step(1'b1, 1'b0, 1'b1);
    check("held_exit", EXT);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("held_armed", ARM);
    step(1'b0, 1'b0, 1'b1);
    check("held_entry", ENT);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      check($sformatf("held_alarm%0d", i), ALM);
    end
    step(1'b0, 1'b0, 1'b1);
    check("rearm_one_cycle", ARM);
    step(1'b0, 1'b0, 1'b1);
    check("reentry", ENT);

    // Async reset in the middle of ALARM drops siren without a clock edge.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    check("alarm_before_reset", ALM);
    #1 rst_n = 1'b0;
    #1;
    check("async_reset_mid_alarm", DIS);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    check("no_resume_after_reset", DIS);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
